// File: rtl/sha3_core_arbiter.sv
// Round-robin arbiter sharing one SHA3/SHAKE core between two requesters.
// Owns the core start pulse, mode hold, data routing and a hung-core watchdog.
module sha3_core_arbiter #(
  parameter int unsigned WDOG_CYC = 4096,
  parameter int unsigned RST_CYC  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_i,
  input  logic [5:0]   cmode_i,
  input  logic [21:0]  d_i,
  input  logic [127:0] dt_i,
  input  logic [1:0]   last_block_i,
  output logic [1:0]   gnt_o,
  output logic [1:0]   valid_o,
  output logic [31:0]  dt_o_hash,
  output logic [1:0]   done_o,
  output logic [1:0]   err_o,
  output logic         core_start,
  output logic [2:0]   core_cmode,
  output logic [10:0]  core_d,
  output logic [63:0]  core_dt_i,
  output logic         core_last_block,
  output logic         core_rst,
  input  logic         core_ready,
  input  logic         core_valid,
  input  logic [31:0]  core_dt_o_hash,
  input  logic         core_finish_hash
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_RECOVER
  } state_t;

  localparam logic [15:0] WD_LAST = 16'(WDOG_CYC - 1);
  localparam logic [3:0]  RC_LAST = 4'(RST_CYC - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        ptr_q, ptr_d;
  logic [2:0]  cmode_q, cmode_d;
  logic [10:0] d_q, d_d;
  logic [15:0] wd_q, wd_d;
  logic [3:0]  rc_q, rc_d;
  logic [1:0]  done_q, done_d;
  logic [1:0]  err_q, err_d;

  logic        grant;
  logic        win;
  logic        active;
  logic [1:0]  own_oh;

  // Arbitration: a lone requester wins outright, a tie goes to ptr.
  always_comb begin
    grant = core_ready && (req_i != 2'b00);
    win   = ptr_q;
    case (req_i)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = ptr_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cmode_d = cmode_q;
    d_d     = d_q;
    wd_d    = wd_q;
    rc_d    = rc_q;
    done_d  = 2'b00;
    err_d   = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          owner_d = win;
          cmode_d = win ? cmode_i[5:3] : cmode_i[2:0];
          d_d     = win ? d_i[21:11] : d_i[10:0];
          wd_d    = 16'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        wd_d    = wd_q + 16'd1;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        wd_d = wd_q + 16'd1;
        // A finish arriving on the timeout cycle still counts as success.
        if (core_finish_hash) begin
          done_d  = owner_q ? 2'b10 : 2'b01;
          ptr_d   = ~owner_q;
          state_d = S_IDLE;
        end else if (wd_q == WD_LAST) begin
          err_d   = owner_q ? 2'b10 : 2'b01;
          rc_d    = 4'd0;
          state_d = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (rc_q == RC_LAST) begin
          ptr_d   = ~owner_q;
          state_d = S_IDLE;
        end else begin
          rc_d = rc_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      cmode_q <= 3'd0;
      d_q     <= 11'd0;
      wd_q    <= 16'd0;
      rc_q    <= 4'd0;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cmode_q <= cmode_d;
      d_q     <= d_d;
      wd_q    <= wd_d;
      rc_q    <= rc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Routing is live only while an owner holds the core.
  always_comb begin
    active          = (state_q == S_START) || (state_q == S_BUSY);
    own_oh          = owner_q ? 2'b10 : 2'b01;
    gnt_o           = active ? own_oh : 2'b00;
    valid_o         = (active && core_valid) ? own_oh : 2'b00;
    dt_o_hash       = core_dt_o_hash;
    done_o          = done_q;
    err_o           = err_q;
    core_start      = (state_q == S_START);
    core_cmode      = cmode_q;
    core_d          = d_q;
    core_dt_i       = 64'd0;
    core_last_block = 1'b0;
    if (active) begin
      core_dt_i       = owner_q ? dt_i[127:64] : dt_i[63:0];
      core_last_block = owner_q ? last_block_i[1] : last_block_i[0];
    end
    core_rst = rst || (state_q == S_RECOVER);
  end

endmodule

// File: tb/tb_sha3_core_arbiter.sv
// Directed and randomized checks of sha3_core_arbiter; the bench acts as the
// two requesters and as the hashing core.
module tb_sha3_core_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [1:0]   req_i;
  logic [5:0]   cmode_i;
  logic [21:0]  d_i;
  logic [127:0] dt_i;
  logic [1:0]   last_block_i;
  logic         core_ready;
  logic         core_valid;
  logic [31:0]  core_dt_o_hash;
  logic         core_finish_hash;

  logic [1:0]  gnt_o, valid_o, done_o, err_o;
  logic [31:0] dt_o_hash;
  logic        core_start, core_last_block, core_rst;
  logic [2:0]  core_cmode;
  logic [10:0] core_d;
  logic [63:0] core_dt_i;

  logic [1:0]  w_gnt, w_valid, w_done, w_err;
  logic [31:0] w_dt_o_hash;
  logic        w_start, w_last_block, w_rst;
  logic [2:0]  w_cmode;
  logic [10:0] w_d;
  logic [63:0] w_dt_i;

  sha3_core_arbiter dut (
    .clk(clk), .rst(rst), .req_i(req_i), .cmode_i(cmode_i), .d_i(d_i),
    .dt_i(dt_i), .last_block_i(last_block_i), .gnt_o(gnt_o), .valid_o(valid_o),
    .dt_o_hash(dt_o_hash), .done_o(done_o), .err_o(err_o),
    .core_start(core_start), .core_cmode(core_cmode), .core_d(core_d),
    .core_dt_i(core_dt_i), .core_last_block(core_last_block),
    .core_rst(core_rst), .core_ready(core_ready), .core_valid(core_valid),
    .core_dt_o_hash(core_dt_o_hash), .core_finish_hash(core_finish_hash)
  );

  // Short-watchdog instance sharing every input with the main one.
  sha3_core_arbiter #(.WDOG_CYC(16), .RST_CYC(2)) dut_w (
    .clk(clk), .rst(rst), .req_i(req_i), .cmode_i(cmode_i), .d_i(d_i),
    .dt_i(dt_i), .last_block_i(last_block_i), .gnt_o(w_gnt), .valid_o(w_valid),
    .dt_o_hash(w_dt_o_hash), .done_o(w_done), .err_o(w_err),
    .core_start(w_start), .core_cmode(w_cmode), .core_d(w_d),
    .core_dt_i(w_dt_i), .core_last_block(w_last_block),
    .core_rst(w_rst), .core_ready(core_ready), .core_valid(core_valid),
    .core_dt_o_hash(core_dt_o_hash), .core_finish_hash(core_finish_hash)
  );

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic finish_after(input int n);
    repeat (n) tick();
    core_finish_hash = 1'b1;
    tick();
    core_finish_hash = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_i = 2'b00; cmode_i = '0; d_i = '0; dt_i = '0; last_block_i = 2'b00;
    core_ready = 1'b1; core_valid = 1'b0; core_dt_o_hash = '0; core_finish_hash = 1'b0;
    tick();
    tick();
    check("rst_core_rst_held", 64'(core_rst), 64'd1);
    rst = 1'b0;
    #1;
    check("rst_outputs_zero", 64'({gnt_o, valid_o, dt_o_hash, done_o, err_o, core_start,
          core_cmode, core_d, core_last_block, core_rst}), 64'd0);
    check("rst_dt_i_zero", core_dt_i, 64'd0);
  endtask

  function automatic logic [1:0] oh(input logic k);
    return k ? 2'b10 : 2'b01;
  endfunction

  int          n_start, n_valid, n_v0;
  logic [31:0] hash_w;
  logic [1:0]  pending;
  logic        mptr, winner;
  logic [2:0]  exp_cmode;
  logic [10:0] exp_d;
  int          len, stall;

  initial begin
    // Single requester with a 40-cycle hash.
    do_reset();
    req_i = 2'b01; cmode_i = 6'd1; d_i = 22'd128;
    dt_i = {64'h0, 64'h8899AABBCCDDEEFF}; last_block_i = 2'b01;
    tick();
    check("single_gnt", 64'(gnt_o), 64'h1);
    check("single_start", 64'(core_start), 64'd1);
    check("single_cmode", 64'(core_cmode), 64'd1);
    check("single_d", 64'(core_d), 64'd128);
    check("single_dt_i", core_dt_i, 64'h8899AABBCCDDEEFF);
    check("single_last", 64'(core_last_block), 64'd1);
    req_i = 2'b00;
    n_start = 0;
    for (int i = 1; i < 40; i++) begin
      tick();
      if (core_start) n_start++;
      if (gnt_o != 2'b01) n_start += 100;
    end
    check("single_start_once_gnt_held", 64'(n_start), 64'd0);
    finish_after(1);
    check("single_done", 64'(done_o), 64'h1);
    check("single_gnt_drop", 64'(gnt_o), 64'h0);
    tick();
    check("single_done_pulse", 64'(done_o), 64'h0);

    // Contention and alternation.
    do_reset();
    req_i = 2'b11;
    tick();
    check("cont_first_gnt", 64'(gnt_o), 64'h1);
    req_i = 2'b10;
    finish_after(5);
    check("cont_done0", 64'(done_o), 64'h1);
    check("cont_gap", 64'(gnt_o), 64'h0);
    tick();
    check("cont_second_gnt", 64'(gnt_o), 64'h2);
    check("cont_second_start", 64'(core_start), 64'd1);
    req_i = 2'b00;
    finish_after(3);
    check("cont_done1", 64'(done_o), 64'h2);
    req_i = 2'b11;
    tick();
    check("cont_alternate", 64'(gnt_o), 64'h1);

    // Mode hold across owner changes.
    do_reset();
    req_i = 2'b01; cmode_i = 6'd3;
    tick();
    check("mode_latched", 64'(core_cmode), 64'd3);
    req_i = 2'b00; cmode_i = 6'd5;
    tick(); tick();
    check("mode_hold", 64'(core_cmode), 64'd3);
    finish_after(2);
    check("mode_done", 64'(done_o), 64'h1);
    check("mode_hold_after", 64'(core_cmode), 64'd3);

    // Output routing to owner 1.
    do_reset();
    req_i = 2'b10;
    tick();
    check("route_gnt", 64'(gnt_o), 64'h2);
    req_i = 2'b00;
    n_valid = 0; n_v0 = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      hash_w = $urandom;
      core_valid = (i % 2 == 0);
      core_dt_o_hash = hash_w;
      #1;
      if (valid_o == 2'b10) n_valid++;
      if (valid_o[0]) n_v0++;
      if (core_valid) check("route_hash", 64'(dt_o_hash), 64'(hash_w));
    end
    core_valid = 1'b0;
    check("route_valid_count", 64'(n_valid), 64'd8);
    check("route_valid0_never", 64'(n_v0), 64'd0);
    finish_after(0);
    check("route_done", 64'(done_o), 64'h2);
    core_valid = 1'b1;
    #1;
    check("route_drop_no_owner", 64'(valid_o), 64'h0);
    core_valid = 1'b0;

    // Watchdog recovery on the 16-cycle instance.
    do_reset();
    req_i = 2'b01;
    tick();
    check("wd_gnt", 64'(w_gnt), 64'h1);
    req_i = 2'b10;
    repeat (15) tick();
    check("wd_last_busy_no_err", 64'({w_err, w_gnt}), 64'h1);
    tick();
    check("wd_err", 64'(w_err), 64'h1);
    check("wd_core_rst1", 64'(w_rst), 64'd1);
    check("wd_gnt_off", 64'(w_gnt), 64'h0);
    core_finish_hash = 1'b1; core_valid = 1'b1;
    #1;
    check("wd_valid_ignored", 64'(w_valid), 64'h0);
    tick();
    core_finish_hash = 1'b0; core_valid = 1'b0;
    #1;
    check("wd_no_done", 64'({w_done, w_err}), 64'h0);
    check("wd_core_rst2", 64'(w_rst), 64'd1);
    tick();
    check("wd_core_rst_end", 64'(w_rst), 64'd0);
    check("wd_idle_gap", 64'(w_gnt), 64'h0);
    tick();
    check("wd_other_gnt", 64'(w_gnt), 64'h2);
    req_i = 2'b00;
    repeat (15) tick();
    finish_after(0);
    check("wd_race_done", 64'(w_done), 64'h2);
    check("wd_race_no_err", 64'(w_err), 64'h0);
    tick();
    check("wd_race_no_err_late", 64'({w_err, w_rst}), 64'h0);

    // Reset mid-hash, then core_ready gating.
    do_reset();
    req_i = 2'b01;
    tick(); tick();
    req_i = 2'b00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_outputs", 64'({gnt_o, valid_o, done_o, err_o, core_start, core_rst,
          core_last_block}), 64'd0);
    tick();
    check("midrst_no_pulse", 64'({done_o, err_o}), 64'd0);
    core_ready = 1'b0; req_i = 2'b01;
    repeat (3) begin
      tick();
      check("notready_no_gnt", 64'(gnt_o), 64'h0);
    end
    core_ready = 1'b1;
    tick();
    check("ready_gnt", 64'(gnt_o), 64'h1);
    finish_after(2);

    // Randomized traffic against a request-set model.
    do_reset();
    pending = 2'b00; mptr = 1'b0;
    for (int t = 0; t < 40; t++) begin
      pending = pending | 2'($urandom_range(0, 3));
      if (pending == 2'b00) pending = oh(1'($urandom_range(0, 1)));
      cmode_i = 6'($urandom); d_i = 22'($urandom);
      dt_i = {$urandom, $urandom, $urandom, $urandom};
      last_block_i = 2'($urandom);
      winner = (pending == 2'b11) ? mptr : pending[1];
      exp_cmode = winner ? cmode_i[5:3] : cmode_i[2:0];
      exp_d = winner ? d_i[21:11] : d_i[10:0];
      req_i = pending;
      stall = $urandom_range(0, 2);
      if (stall > 0) begin
        core_ready = 1'b0;
        repeat (stall) begin
          tick();
          check("rnd_stall_no_gnt", 64'(gnt_o), 64'h0);
        end
        core_ready = 1'b1;
      end
      tick();
      check("rnd_gnt", 64'(gnt_o), 64'(oh(winner)));
      check("rnd_start", 64'(core_start), 64'd1);
      check("rnd_cmode", 64'(core_cmode), 64'(exp_cmode));
      check("rnd_d", 64'(core_d), 64'(exp_d));
      check("rnd_dt_i", core_dt_i, winner ? dt_i[127:64] : dt_i[63:0]);
      pending = pending & ~oh(winner);
      req_i = pending;
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        tick();
        cmode_i = 6'($urandom);
        dt_i = {$urandom, $urandom, $urandom, $urandom};
        core_valid = 1'($urandom);
        hash_w = $urandom;
        core_dt_o_hash = hash_w;
        #1;
        check("rnd_valid", 64'(valid_o), core_valid ? 64'(oh(winner)) : 64'h0);
        check("rnd_hash", 64'(dt_o_hash), 64'(hash_w));
        check("rnd_cmode_hold", 64'(core_cmode), 64'(exp_cmode));
        check("rnd_dt_route", core_dt_i, winner ? dt_i[127:64] : dt_i[63:0]);
      end
      finish_after(0);
      core_valid = 1'b0;
      check("rnd_done", 64'(done_o), 64'(oh(winner)));
      check("rnd_gnt_drop", 64'(gnt_o), 64'h0);
      mptr = ~winner;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
